// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline control logic.
package core_pkg;

  // Memory-wait tracking states of the hazard controller.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  // Canonical NOP (addi x0, x0, 0) loaded into IF/ID on a flush.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // x0 is hard-wired to zero, so it can never create a data hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up until all-ones and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush controller: load-use, EX branch redirect and data-memory
// wait handling with a watchdog, plus saturating stall/flush counters.
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter  int MEM_TIMEOUT = 64,
  parameter  int CNT_W       = 32,
  localparam int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clear,
  output logic             pc_write_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  hz_state_t       state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic load_use;
  logic mem_stall_run;
  logic freeze;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mem_stall_run = mem_req && !mem_ready;

  // Whole pipe holds while memory is outstanding or after a watchdog trip.
  assign freeze = (state_q == ERR) ||
                  ((state_q == MEM_WAIT) && !mem_ready) ||
                  ((state_q == RUN) && mem_stall_run);

  // State, watchdog and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic for the memory-wait tracker and its watchdog.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall_run) begin
          state_d = MEM_WAIT;
          wd_d    = TO_ONE;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wd_d    = '0;
        end else if (wd_q == TO_LIMIT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control outputs: freeze beats branch flush beats load-use bubble.
  always_comb begin
    pc_write_en  = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset_n) begin
      pc_write_en = 1'b1;
    end else if (freeze) begin
      pc_write_en  = 1'b0;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so its hazard is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write_en = 1'b0;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clear),
    .inc     (!pc_write_en),
    .q       (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clear),
    .inc     (if_id_flush),
    .q       (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_hazard_ctrl_unit;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b0, cnt_clear = 1'b0;
  logic          pc_write_en, if_id_stall, if_id_flush, id_ex_stall;
  logic          id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout_err;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .cnt_clear       (cnt_clear),
    .pc_write_en     (pc_write_en),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  int checks = 0;
  int errors = 0;

  // Model: "waiting on memory", "tripped", consecutive wait length, counters.
  bit m_wait, m_err;
  int m_wd, m_stall, m_flush;

  // DUT outputs captured at the last mid-cycle sample.
  logic l_pc, l_ifs, l_iff, l_ids, l_idf, l_exs, l_mwf, l_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_wd = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clear = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    bit hz, frz;
    bit e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_mwf;
    bit n_wait, n_err;
    int n_wd, n_stall, n_flush;
    @(negedge clk);
    if (!reset_n) model_reset();
    hz  = ex_mem_read && (ex_rd != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    frz = m_err || (m_wait ? !mem_ready : (mem_req && !mem_ready));
    e_pc = 1; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_exs = 0; e_mwf = 0;
    if (reset_n) begin
      if (frz) begin
        e_pc = 0; e_ifs = 1; e_ids = 1; e_exs = 1; e_mwf = 1;
      end else if (ex_branch_taken) begin
        e_iff = 1; e_idf = 1;
      end else if (hz) begin
        e_pc = 0; e_ifs = 1; e_idf = 1;
      end
    end
    l_pc = pc_write_en; l_ifs = if_id_stall; l_iff = if_id_flush; l_ids = id_ex_stall;
    l_idf = id_ex_flush; l_exs = ex_mem_stall; l_mwf = mem_wb_flush; l_err = mem_timeout_err;
    chk("pc_write_en", 32'(l_pc), 32'(e_pc));
    chk("if_id_stall", 32'(l_ifs), 32'(e_ifs));
    chk("if_id_flush", 32'(l_iff), 32'(e_iff));
    chk("id_ex_stall", 32'(l_ids), 32'(e_ids));
    chk("id_ex_flush", 32'(l_idf), 32'(e_idf));
    chk("ex_mem_stall", 32'(l_exs), 32'(e_exs));
    chk("mem_wb_flush", 32'(l_mwf), 32'(e_mwf));
    chk("mem_timeout_err", 32'(l_err), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_events", 32'(flush_events), 32'(m_flush));
    n_wait = m_wait; n_err = m_err; n_wd = m_wd;
    if (!m_err) begin
      if (m_wait) begin
        if (mem_ready) begin n_wait = 0; n_wd = 0; end
        else if (m_wd == MT) n_err = 1;
        else n_wd = m_wd + 1;
      end else if (mem_req && !mem_ready) begin
        n_wait = 1; n_wd = 1;
      end
    end
    n_stall = cnt_clear ? 0 : ((!e_pc && m_stall < CMAX) ? m_stall + 1 : m_stall);
    n_flush = cnt_clear ? 0 : ((e_iff && m_flush < CMAX) ? m_flush + 1 : m_flush);
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else begin
      m_wait = n_wait; m_err = n_err; m_wd = n_wd; m_stall = n_stall; m_flush = n_flush;
    end
  endtask

  initial begin
    model_reset();
    idle();
    #2 reset_n = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("lit_reset_pc", 32'(l_pc), 32'd1);
    chk("lit_reset_stall_cnt", 32'(stall_cycles), 32'd0);
    $display("reset: pc_write_en=%0b stall_cycles=%0d", l_pc, stall_cycles);
    reset_n = 1;
    cycle();

    // Load-use for one cycle.
    set_load_use();
    cycle();
    chk("lit_lu_pc", 32'(l_pc), 32'd0);
    chk("lit_lu_ifs", 32'(l_ifs), 32'd1);
    chk("lit_lu_idf", 32'(l_idf), 32'd1);
    chk("lit_lu_stall_cnt", 32'(stall_cycles), 32'd1);
    idle();
    cycle();
    chk("lit_lu_release_pc", 32'(l_pc), 32'd1);
    $display("load-use: stall_cycles=%0d", stall_cycles);

    // x0 is never a hazard.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cycle();
    chk("lit_x0_pc", 32'(l_pc), 32'd1);
    chk("lit_x0_ifs", 32'(l_ifs), 32'd0);
    chk("lit_x0_idf", 32'(l_idf), 32'd0);
    $display("x0 exemption: pc_write_en=%0b", l_pc);

    // Branch beats load-use.
    idle(); set_load_use(); ex_branch_taken = 1;
    cycle();
    chk("lit_br_pc", 32'(l_pc), 32'd1);
    chk("lit_br_iff", 32'(l_iff), 32'd1);
    chk("lit_br_idf", 32'(l_idf), 32'd1);
    chk("lit_br_ifs", 32'(l_ifs), 32'd0);
    chk("lit_br_flush_cnt", 32'(flush_events), 32'd1);
    $display("branch over load-use: flush_events=%0d", flush_events);

    idle(); cnt_clear = 1;
    cycle();
    chk("lit_clear_stall_cnt", 32'(stall_cycles), 32'd0);
    idle();

    // Memory wait of three cycles, released on the fourth.
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lit_mw_pc", 32'(l_pc), 32'd0);
    end
    mem_ready = 1;
    cycle();
    chk("lit_mw_release_pc", 32'(l_pc), 32'd1);
    chk("lit_mw_stall_cnt", 32'(stall_cycles), 32'd3);
    idle();
    cycle();
    chk("lit_mw_run_pc", 32'(l_pc), 32'd1);
    $display("memory wait: stall_cycles=%0d", stall_cycles);

    // Watchdog trip, then reset out of the permanent freeze.
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MT + 3; i++) cycle();
    chk("lit_wd_err", 32'(mem_timeout_err), 32'd1);
    mem_ready = 1;
    cycle();
    chk("lit_wd_frozen_pc", 32'(l_pc), 32'd0);
    reset_n = 0;
    cycle();
    chk("lit_wd_reset_pc", 32'(l_pc), 32'd1);
    chk("lit_wd_reset_err", 32'(l_err), 32'd0);
    idle(); reset_n = 1;
    cycle();
    chk("lit_wd_after_pc", 32'(l_pc), 32'd1);
    $display("watchdog: err cleared by reset, pc_write_en=%0b", l_pc);

    // Saturation and clear.
    set_load_use();
    for (int i = 0; i < 20; i++) cycle();
    chk("lit_sat_stall_cnt", 32'(stall_cycles), 32'd15);
    cnt_clear = 1;
    cycle();
    chk("lit_sat_cleared", 32'(stall_cycles), 32'd0);
    cnt_clear = 0;
    cycle();
    chk("lit_sat_restart", 32'(stall_cycles), 32'd1);
    $display("saturation: stall_cycles=%0d after restart", stall_cycles);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n         = ($urandom_range(0, 199) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 2) != 0);
      cnt_clear       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    $display("random: 3000 cycles applied");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central pipeline controller for the 5-stage RV32 core.
- Generates the stall and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three hazard sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory waits.
- Tracks memory waits with a small FSM and watchdog, and keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive cycles in MEM_WAIT before an error is declared (must be ≥ 2).
- CNT_W, 32: width of each performance counter.
- TO_W, $clog2(MEM_TIMEOUT+1): width of the watchdog counter (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump (PC redirect).
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- cnt_clear  in  1  synchronous clear of both performance counters.
- pc_write_en  out  1  PC register load enable.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  load a bubble into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_flush  out  1  load a bubble into MEM/WB.
- mem_timeout_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  count of cycles with pc_write_en=0.
- flush_events  out  CNT_W  count of cycles in which a branch flush was issued.

Behaviour:
- Control outputs are combinational from the FSM state and the current inputs. State, watchdog, error flag and counters are registered.
- FSM states are RUN, MEM_WAIT and ERR. Reset state is RUN.
- Reset (reset_n=0, asynchronous):
  - state=RUN, watchdog=0, mem_timeout_err=0, both counters=0.
  - Outputs while in reset: pc_write_en=1, all stall/flush outputs=0.
- Definition of freeze: pc_write_en=0, if_id_stall=1, id_ex_stall=1, ex_mem_stall=1, mem_wb_flush=1; all flush outputs other than mem_wb_flush are 0.
- Definition of load-use hazard: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Priority in RUN, highest first:
  1. Memory wait: mem_req && !mem_ready → freeze; next state MEM_WAIT; watchdog=1.
  2. Branch: ex_branch_taken → if_id_flush=1, id_ex_flush=1, pc_write_en=1. Any simultaneous load-use hazard is ignored because the ID instruction is wrong-path.
  3. Load-use hazard → pc_write_en=0, if_id_stall=1, id_ex_flush=1. This lasts exactly one cycle, because the load advances to MEM on the next cycle.
  4. Otherwise: pc_write_en=1, all stall/flush outputs=0.
- MEM_WAIT:
  - mem_ready=1: no freeze this cycle; outputs are evaluated by the RUN rules 2–4 with the memory-wait rule masked; next state RUN; watchdog=0.
  - mem_ready=0 with watchdog==MEM_TIMEOUT: freeze; next state ERR; mem_timeout_err=1.
  - mem_ready=0 otherwise: freeze; watchdog increments.
- Branch or load-use inputs seen during a freeze are suppressed. The instructions stay in place and are re-evaluated after release.
- ERR: permanent freeze, and mem_timeout_err stays 1, until reset_n is asserted.
- stall_cycles: increments in every cycle with pc_write_en=0 (freeze or load-use). flush_events: increments in every cycle with if_id_flush=1.
- Both counters saturate at all-ones. cnt_clear has priority over increment: the counter reads 0 on the next cycle.
- A reset in the middle of MEM_WAIT or ERR returns to RUN immediately and clears the error flag.

Decomposition:
- A shared package core_pkg holds:
  - the typedef enum logic[1:0] hz_state_t {RUN, MEM_WAIT, ERR};
  - the constant NOP_INSTR=32'h00000013;
  - the constant REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W; ports clk, reset_n, clr, inc, q), is instantiated twice, once for each performance counter.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_write_en=0, if_id_stall=1, id_ex_flush=1 for 1 cycle; stall_cycles=1.
- x0 exemption: ex_rd=0, id_rs1=0, id_uses_rs1=1, ex_mem_read=1 → no stall, all stall/flush outputs 0.
- Branch beats load-use: ex_branch_taken=1 in the same cycle as a load-use hazard → if_id_flush=1, id_ex_flush=1, pc_write_en=1, no stall; flush_events=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → freeze for 3 cycles, release in cycle 4, state returns to RUN; stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, mem_req=1, mem_ready held at 0 → mem_timeout_err=1 and permanent freeze; then assert reset_n=0 mid-freeze → error clears, outputs return to the reset values, state is RUN.
- Counter saturation and clear: CNT_W=4 with a stall held for 20 cycles → stall_cycles=15 and holds; pulse cnt_clear → stall_cycles=0 on the next cycle.
